// File: rtl/lut_neuron_array.sv
// Array of run-time loadable truth-table neurons with a two-stage valid/ready lookup pipeline.
// Any table write first drains the pipeline, so in-flight beats always see a consistent table.
//
// state | meaning
// RUN   | accepting beats, tables read-only
// DRAIN | input closed, waiting for S1/S2 to empty
// LOAD  | cfg port open, table writes until cfg_last
module lut_neuron_array #(
  parameter int N_NEURONS = 4,
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 1,
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [NW-1:0]                 cfg_neuron,
  input  logic [IN_BITS-1:0]            cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_data,
  input  logic                          cfg_last,
  output logic                          busy
);

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

  state_t state, state_nxt;

  logic                          s1_valid;
  logic [N_NEURONS*IN_BITS-1:0]  s1_data;
  logic                          s1_adv, s2_adv, accept;
  logic                          cfg_hit, cfg_we;
  logic [N_NEURONS*OUT_BITS-1:0] lookup;

  // No reset on the tables: contents persist across rst.
  logic [OUT_BITS-1:0] table_mem [N_NEURONS][2**IN_BITS];

  assign s2_adv    = !out_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = !rst && (state == RUN) && s1_adv;
  assign accept    = in_valid && in_ready;
  assign cfg_ready = !rst && (state == LOAD);
  assign busy      = !rst && ((state == DRAIN) || (state == LOAD));
  assign cfg_we    = cfg_ready && cfg_valid && cfg_hit;

  // Out-of-range neuron indices match nothing and are silently dropped.
  always_comb begin
    cfg_hit = 1'b0;
    for (int k = 0; k < N_NEURONS; k++) begin
      if (cfg_neuron == NW'(k)) cfg_hit = 1'b1;
    end
  end

  always_comb begin
    lookup = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      lookup[k*OUT_BITS +: OUT_BITS] = table_mem[k][s1_data[k*IN_BITS +: IN_BITS]];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_NEURONS; k++) begin
      if (cfg_we && (cfg_neuron == NW'(k))) table_mem[k][cfg_addr] <= cfg_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (cfg_valid) state_nxt = DRAIN;
      DRAIN:   if (!out_valid && !s1_valid) state_nxt = LOAD;
      LOAD:    if (cfg_valid && cfg_last) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) s1_data <= in_data;
      end
      // out_data only moves when S2 may advance, so it holds under backpressure.
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) out_data <= lookup;
      end
    end
  end

endmodule
